// File: rtl/tt_scanner_if.sv
// Stimulus/response and result bundle between the truth-table scanner and the
// logic under test; the master side drives the request and observes results.
interface tt_scanner_if;
    logic        start;
    logic [15:0] expect_mask;
    logic        y;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic [4:0]  err_count;
    logic        pass;

    modport master (
        output start, expect_mask, y,
        input  a, b, c, d, busy, done, table_out, err_count, pass
    );

    modport slave (
        input  start, expect_mask, y,
        output a, b, c, d, busy, done, table_out, err_count, pass
    );
endinterface

// File: rtl/tt_scanner.sv
// Exhaustive truth-table scanner: walks all 16 input vectors of a 4-input
// combinational stage, captures y for each and compares it against a latched mask.
module tt_scanner #(
    parameter int SETTLE = 1  // cycles each vector is held before sampling, 1..15
) (
    input  logic         clk,
    input  logic         rst,
    tt_scanner_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q, state_n;
    logic [3:0]  idx_q, idx_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [15:0] mask_q, mask_n;
    logic [15:0] table_q, table_n;
    logic [4:0]  err_q, err_n;
    logic        pass_q, pass_n;

    logic [3:0]  abcd_q, abcd_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;

    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        mask_n  = mask_q;
        table_n = table_q;
        err_n   = err_q;
        pass_n  = pass_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = DRIVE;
                    idx_n   = 4'd0;
                    cnt_n   = 4'd0;
                    mask_n  = bus.expect_mask;
                    table_n = 16'h0000;
                    err_n   = 5'd0;
                    pass_n  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_n = SAMPLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                table_n[idx_q] = bus.y;
                if (bus.y != mask_q[idx_q]) begin
                    err_n = err_q + 5'd1;
                end
                if (idx_q == 4'd15) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx_q + 4'd1;
                    state_n = DRIVE;
                end
            end
            DONE: begin
                pass_n  = (err_q == 5'd0);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        // without lagging the state they describe.
        busy_n = (state_n == DRIVE) || (state_n == SAMPLE);
        done_n = (state_n == DONE);
        abcd_n = busy_n ? idx_n : 4'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            mask_q  <= 16'h0000;
            table_q <= 16'h0000;
            err_q   <= 5'd0;
            pass_q  <= 1'b0;
            abcd_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            mask_q  <= mask_n;
            table_q <= table_n;
            err_q   <= err_n;
            pass_q  <= pass_n;
            abcd_q  <= abcd_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.a         = abcd_q[3];
    assign bus.b         = abcd_q[2];
    assign bus.c         = abcd_q[1];
    assign bus.d         = abcd_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.err_count = err_q;
    assign bus.pass      = pass_q;

endmodule
